// File: rtl/psu_maskext.sv
// Scatters the compact per-(patch, unit-cell, qubit) mask and special flags into the
// extended physical-qubit arrays, one compact index per cycle, and hands them off with valid/ready.
`ifndef NUM_PCU
`define NUM_PCU 2
`endif
`ifndef NUM_UCC
`define NUM_UCC 1
`endif
`ifndef NUM_QBCTRL
`define NUM_QBCTRL 2
`endif
`ifndef NUM_UC
`define NUM_UC 2
`endif
`ifndef NUM_QB
`define NUM_QB 4
`endif
`ifndef NUM_PQ
`define NUM_PQ 32
`endif
`ifndef PCHSTAT_BW
`define PCHSTAT_BW 2
`endif
`ifndef PCHDYN_BW
`define PCHDYN_BW 2
`endif
`ifndef PCHADDR_BW
`define PCHADDR_BW 4
`endif
`ifndef PCHINFO_BW
`define PCHINFO_BW 10
`endif
`ifndef UCADDR_BW
`define UCADDR_BW 4
`endif
`ifndef QBADDR_BW
`define QBADDR_BW 4
`endif

module psu_maskext #(
    parameter int NUM_PCU    = `NUM_PCU,
    parameter int NUM_UCC    = `NUM_UCC,
    parameter int NUM_QBCTRL = `NUM_QBCTRL,
    parameter int NUM_UC     = `NUM_UC,
    parameter int NUM_QB     = `NUM_QB,
    parameter int NUM_PQ     = `NUM_PQ,
    localparam int NUM_MASK  = NUM_PCU*NUM_UCC*NUM_QBCTRL
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [NUM_PCU*(`PCHINFO_BW+1)-1:0]     pchinfo_list,
    input  logic [NUM_UCC*`UCADDR_BW-1:0]          uc_counter,
    input  logic [NUM_QBCTRL*`QBADDR_BW-1:0]       qb_counter,
    input  logic [NUM_MASK-1:0]                    mask_array,
    input  logic [NUM_MASK-1:0]                    special_array,
    output logic                                   busy,
    output logic                                   ext_valid,
    input  logic                                   ext_ready,
    output logic [NUM_PQ-1:0]                      mask_ext_array,
    output logic [NUM_PQ-1:0]                      special_ext_array,
    output logic                                   idx_err
);

    localparam int PB   = `PCHINFO_BW;
    localparam int PE   = PB + 1;
    localparam int AB   = `PCHADDR_BW;
    localparam int ALSB = PB - `PCHSTAT_BW - `PCHDYN_BW - AB;
    localparam int UB   = `UCADDR_BW;
    localparam int QBW  = `QBADDR_BW;
    localparam int UQ   = NUM_UCC*NUM_QBCTRL;
    localparam int SW   = (NUM_MASK > 1) ? $clog2(NUM_MASK) : 1;
    localparam int PQW  = (NUM_PQ > 1) ? $clog2(NUM_PQ) : 1;
    // Wide enough for the largest pch/uc/qb combination the field widths allow.
    localparam int TW   = AB + UB + QBW + $clog2(NUM_UC*NUM_QB + 1) + 2;

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

    state_t                             state_q, state_d;
    logic [SW-1:0]                      sidx_q, sidx_d;
    logic [NUM_PCU*PE-1:0]              pchinfo_q, pchinfo_d;
    logic [NUM_UCC*UB-1:0]              uc_q, uc_d;
    logic [NUM_QBCTRL*QBW-1:0]          qb_q, qb_d;
    logic [NUM_MASK-1:0]                mask_q, mask_d;
    logic [NUM_MASK-1:0]                special_q, special_d;
    logic [NUM_PQ-1:0]                  mask_ext_q, mask_ext_d;
    logic [NUM_PQ-1:0]                  special_ext_q, special_ext_d;
    logic                               idx_err_q, idx_err_d;

    int                                 i_idx, j_idx, k_idx;
    logic                               entry_vld;
    logic [AB-1:0]                      pch;
    logic [UB-1:0]                      uc_val;
    logic [QBW-1:0]                     qb_val;
    logic [TW-1:0]                      target;
    logic                               in_range;

    // Decode the current compact index into (entry, unit-cell counter, qubit counter).
    always_comb begin
        i_idx     = int'(sidx_q) / UQ;
        j_idx     = (int'(sidx_q) % UQ) / NUM_QBCTRL;
        k_idx     = int'(sidx_q) % NUM_QBCTRL;
        entry_vld = pchinfo_q[i_idx*PE + PB];
        pch       = pchinfo_q[i_idx*PE + ALSB +: AB];
        uc_val    = uc_q[j_idx*UB +: UB];
        qb_val    = qb_q[k_idx*QBW +: QBW];
        target    = TW'(pch) * TW'(NUM_UC*NUM_QB) + TW'(uc_val) * TW'(NUM_QB) + TW'(qb_val);
        in_range  = (target < TW'(NUM_PQ));
    end

    always_comb begin
        state_d       = state_q;
        sidx_d        = sidx_q;
        pchinfo_d     = pchinfo_q;
        uc_d          = uc_q;
        qb_d          = qb_q;
        mask_d        = mask_q;
        special_d     = special_q;
        mask_ext_d    = mask_ext_q;
        special_ext_d = special_ext_q;
        idx_err_d     = idx_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pchinfo_d = pchinfo_list;
                    uc_d      = uc_counter;
                    qb_d      = qb_counter;
                    mask_d    = mask_array;
                    special_d = special_array;
                    idx_err_d = 1'b0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                mask_ext_d    = '0;
                special_ext_d = '0;
                sidx_d        = '0;
                state_d       = SCAN;
            end
            SCAN: begin
                // Later indices overwrite earlier ones on collision simply by scan order.
                if (entry_vld) begin
                    if (in_range) begin
                        mask_ext_d[target[PQW-1:0]]    = mask_q[sidx_q];
                        special_ext_d[target[PQW-1:0]] = special_q[sidx_q];
                    end else begin
                        idx_err_d = 1'b1;
                    end
                end
                if (sidx_q == SW'(NUM_MASK-1)) begin
                    sidx_d  = '0;
                    state_d = DONE;
                end else begin
                    sidx_d = sidx_q + SW'(1);
                end
            end
            DONE: begin
                if (ext_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sidx_q        <= '0;
            pchinfo_q     <= '0;
            uc_q          <= '0;
            qb_q          <= '0;
            mask_q        <= '0;
            special_q     <= '0;
            mask_ext_q    <= '0;
            special_ext_q <= '0;
            idx_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sidx_q        <= sidx_d;
            pchinfo_q     <= pchinfo_d;
            uc_q          <= uc_d;
            qb_q          <= qb_d;
            mask_q        <= mask_d;
            special_q     <= special_d;
            mask_ext_q    <= mask_ext_d;
            special_ext_q <= special_ext_d;
            idx_err_q     <= idx_err_d;
        end
    end

    assign busy              = (state_q != IDLE);
    assign ext_valid         = (state_q == DONE);
    assign mask_ext_array    = mask_ext_q;
    assign special_ext_array = special_ext_q;
    assign idx_err           = idx_err_q;

endmodule

// File: tb/tb_psu_maskext.sv
// Directed and randomized scatter passes for psu_maskext; expected arrays are queued at
// start and compared when ext_valid rises.
module tb_psu_maskext;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [21:0] pchinfo_list;
    logic [3:0]  uc_counter;
    logic [7:0]  qb_counter;
    logic [3:0]  mask_array;
    logic [3:0]  special_array;
    logic        busy;
    logic        ext_valid;
    logic        ext_ready;
    logic [31:0] mask_ext_array;
    logic [31:0] special_ext_array;
    logic        idx_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_edges;
    logic        pulse_start = 1'b0;
    logic [64:0] exp_q[$];
    logic [64:0] cur;

    psu_maskext #(
        .NUM_PCU(2), .NUM_UCC(1), .NUM_QBCTRL(2), .NUM_UC(2), .NUM_QB(4), .NUM_PQ(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pchinfo_list(pchinfo_list),
        .uc_counter(uc_counter), .qb_counter(qb_counter), .mask_array(mask_array),
        .special_array(special_array), .busy(busy), .ext_valid(ext_valid),
        .ext_ready(ext_ready), .mask_ext_array(mask_ext_array),
        .special_ext_array(special_ext_array), .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry = {valid, stat=11, dyn=01, pch, low=10}; pch sits at bits [5:2].
    function automatic logic [10:0] ent(input logic v, input logic [3:0] p);
        return {v, 2'b11, 2'b01, p, 2'b10};
    endfunction

    function automatic logic [64:0] model(input logic [10:0] e0, input logic [10:0] e1,
                                          input logic [3:0] uc, input logic [7:0] qb,
                                          input logic [3:0] m, input logic [3:0] s);
        logic [31:0] em = '0;
        logic [31:0] es = '0;
        logic        ee = 1'b0;
        logic [10:0] e;
        int          t;
        for (int sx = 0; sx < 4; sx++) begin
            e = (sx < 2) ? e0 : e1;
            if (e[10]) begin
                t = int'(e[5:2]) * 8 + int'(uc) * 4 + ((sx % 2 == 1) ? int'(qb[7:4]) : int'(qb[3:0]));
                if (t < 32) begin
                    em[t] = m[sx];
                    es[t] = s[sx];
                end else begin
                    ee = 1'b1;
                end
            end
        end
        return {ee, es, em};
    endfunction

    task automatic start_pass(input logic [10:0] e0, input logic [10:0] e1, input logic [3:0] uc,
                              input logic [7:0] qb, input logic [3:0] m, input logic [3:0] s,
                              input logic [64:0] exp);
        @(negedge clk);
        rst_n         = 1'b1;
        pchinfo_list  = {e1, e0};
        uc_counter    = uc;
        qb_counter    = qb;
        mask_array    = m;
        special_array = s;
        start         = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start         = 1'b0;
        pchinfo_list  = 22'($urandom);
        uc_counter    = 4'($urandom);
        qb_counter    = 8'($urandom);
        mask_array    = 4'($urandom);
        special_array = 4'($urandom);
        n_edges       = 1;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("idx_err_cleared", {63'd0, idx_err}, 64'd0);
    endtask

    task automatic wait_and_check(input string tag);
        while (!ext_valid && n_edges < 40) begin
            @(posedge clk); #1;
            n_edges++;
            start = (n_edges == 3) ? pulse_start : 1'b0;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(n_edges), 64'd6);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'd0, 64'd1);
            cur = '0;
        end else begin
            cur = exp_q.pop_front();
        end
        chk({tag, "_mask"}, 64'(mask_ext_array), 64'(cur[31:0]));
        chk({tag, "_special"}, 64'(special_ext_array), 64'(cur[63:32]));
        chk({tag, "_idx_err"}, {63'd0, idx_err}, {63'd0, cur[64]});
    endtask

    task automatic hold_and_release(input string tag, input int hold);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            ext_ready = 1'b0;
            start     = (c == 2);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {63'd0, ext_valid}, 64'd1);
            chk({tag, "_hold_mask"}, 64'(mask_ext_array), 64'(cur[31:0]));
        end
        @(negedge clk);
        start     = 1'b0;
        ext_ready = 1'b1;
        @(posedge clk); #1;
        ext_ready = 1'b0;
        chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_idle_valid"}, {63'd0, ext_valid}, 64'd0);
        chk({tag, "_idle_mask"}, 64'(mask_ext_array), 64'(cur[31:0]));
        chk({tag, "_idle_special"}, 64'(special_ext_array), 64'(cur[63:32]));
    endtask

    initial begin
        logic [10:0] r0, r1;
        logic [3:0]  ru, rm, rs;
        logic [7:0]  rq;

        rst_n = 1'b0; start = 1'b0; ext_ready = 1'b0;
        pchinfo_list = '0; uc_counter = '0; qb_counter = '0;
        mask_array = '0; special_array = '0;
        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_valid", {63'd0, ext_valid}, 64'd0);
        chk("reset_mask", 64'(mask_ext_array), 64'd0);
        chk("reset_special", 64'(special_ext_array), 64'd0);
        chk("reset_idx_err", {63'd0, idx_err}, 64'd0);

        // Basic scatter; start arrives on the first edge after reset release.
        start_pass(ent(1, 1), ent(1, 3), 4'd1, {4'd2, 4'd0}, 4'b1011, 4'b0010,
                   {1'b0, 32'h0000_4000, 32'h4000_5000});
        wait_and_check("basic");
        hold_and_release("basic", 0);

        start_pass(ent(1, 1), ent(0, 3), 4'd1, {4'd2, 4'd0}, 4'b1011, 4'b0010,
                   {1'b0, 32'h0000_4000, 32'h0000_5000});
        wait_and_check("invalid");
        hold_and_release("invalid", 0);

        start_pass(ent(1, 1), ent(1, 4), 4'd1, {4'd2, 4'd0}, 4'b1011, 4'b0010,
                   {1'b1, 32'h0000_4000, 32'h0000_5000});
        wait_and_check("range");
        hold_and_release("range", 0);

        // Backpressure with start pulses in SCAN and DONE.
        pulse_start = 1'b1;
        start_pass(ent(1, 1), ent(1, 3), 4'd1, {4'd2, 4'd0}, 4'b1011, 4'b0010,
                   {1'b0, 32'h0000_4000, 32'h4000_5000});
        wait_and_check("bp");
        pulse_start = 1'b0;
        hold_and_release("bp", 10);
        @(posedge clk); #1;
        chk("bp_no_restart", {63'd0, busy}, 64'd0);

        start_pass(ent(1, 1), ent(1, 1), 4'd1, {4'd2, 4'd0}, 4'b0001, 4'b0100,
                   {1'b0, 32'h0000_1000, 32'h0000_0000});
        wait_and_check("collision");
        hold_and_release("collision", 0);

        // Reset while sidx=2.
        start_pass(ent(1, 1), ent(1, 3), 4'd1, {4'd2, 4'd0}, 4'b1011, 4'b0010,
                   {1'b0, 32'h0000_4000, 32'h4000_5000});
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_valid", {63'd0, ext_valid}, 64'd0);
        chk("midreset_mask", 64'(mask_ext_array), 64'd0);
        chk("midreset_special", 64'(special_ext_array), 64'd0);
        void'(exp_q.pop_back());
        start_pass(ent(1, 1), ent(1, 3), 4'd1, {4'd2, 4'd0}, 4'b1011, 4'b0010,
                   {1'b0, 32'h0000_4000, 32'h4000_5000});
        wait_and_check("after_reset");
        hold_and_release("after_reset", 0);

        for (int n = 0; n < 6; n++) begin
            r0 = ent(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)));
            r1 = ent(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)));
            ru = 4'($urandom_range(0, 1));
            rq = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
            rm = 4'($urandom_range(0, 15));
            rs = 4'($urandom_range(0, 15));
            start_pass(r0, r1, ru, rq, rm, rs, model(r0, r1, ru, rq, rm, rs));
            wait_and_check("random");
            hold_and_release("random", $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psu_maskext.md
PSU_MASKEXT -- requirements
Module: psu_maskext

Interface
REQ-001 SHALL have parameter NUM_PCU, default `NUM_PCU: number of patch control units (pchinfo entries).
REQ-002 SHALL have parameter NUM_UCC, default `NUM_UCC: number of unit-cell counters.
REQ-003 SHALL have parameter NUM_QBCTRL, default `NUM_QBCTRL: number of qubit counters.
REQ-004 SHALL have parameter NUM_UC, default `NUM_UC: unit cells per patch.
REQ-005 SHALL have parameter NUM_QB, default `NUM_QB: qubits per unit cell.
REQ-006 SHALL have parameter NUM_PQ, default `NUM_PQ: physical qubits in the extended array.
REQ-007 SHALL derive NUM_MASK = NUM_PCU*NUM_UCC*NUM_QBCTRL internally.
REQ-008 SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-009 SHALL have the following ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request one scatter pass.
- pchinfo_list, input, NUM_PCU*(`PCHINFO_BW+1): per-entry {valid, pchinfo}.
- uc_counter, input, NUM_UCC*`UCADDR_BW: unit-cell indices.
- qb_counter, input, NUM_QBCTRL*`QBADDR_BW: qubit indices.
- mask_array, input, NUM_MASK: compact mask.
- special_array, input, NUM_MASK: compact special flags.
- busy, output, 1: pass in progress.
- ext_valid, output, 1: extended arrays ready.
- ext_ready, input, 1: consumer accepts the arrays.
- mask_ext_array, output, NUM_PQ: extended mask feeding psu_cwdarrgen.
- special_ext_array, output, NUM_PQ: extended special flags feeding psu_cwdarrgen.
- idx_err, output, 1: sticky out-of-range target flag.

Function
REQ-010 SHALL implement states IDLE, CLEAR, SCAN, DONE.
REQ-011 In IDLE with start=1: SHALL register all five data inputs, clear idx_err, and go to CLEAR; start outside IDLE SHALL be ignored.
REQ-012 CLEAR SHALL zero both ext arrays for one cycle, then enter SCAN with sidx=0.
REQ-013 SCAN SHALL process one sidx per cycle, from 0 to NUM_MASK-1, using registered copies only.
- I = sidx/(NUM_UCC*NUM_QBCTRL).
- J = (sidx%(NUM_UCC*NUM_QBCTRL))/NUM_QBCTRL.
- K = sidx%NUM_QBCTRL.
REQ-014 The patch index SHALL be pchinfo[`PCHINFO_BW-1-`PCHSTAT_BW-`PCHDYN_BW -: `PCHADDR_BW] of entry I.
REQ-015 The target index SHALL be T = pch*NUM_UC*NUM_QB + uc_counter[J]*NUM_QB + qb_counter[K], computed at a width that cannot overflow.
REQ-016 If entry I is valid and T < NUM_PQ: SHALL set mask_ext[T] = mask_array[sidx] and special_ext[T] = special_array[sidx].
REQ-017 If entry I is invalid: no write.
REQ-018 If T >= NUM_PQ: no write, and idx_err SHALL be set (sticky until the next accepted start).
REQ-019 On index collisions the higher sidx SHALL win (last write).
REQ-020 After sidx=NUM_MASK-1, SHALL enter DONE; ext_valid=1 exactly in DONE, first asserted start+NUM_MASK+2 cycles after the accepted start edge.
REQ-021 In DONE, ext arrays SHALL hold stable until the ext_valid&&ext_ready edge, then return to IDLE; arrays SHALL keep their value in IDLE.
REQ-022 busy SHALL be 1 in CLEAR, SCAN and DONE.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, sidx=0, busy=0, ext_valid=0, idx_err=0, and both ext arrays to 0, including mid-SCAN.
REQ-024 After rst_n release, start SHALL be honoured on the first rising clk edge.

Verification
Bench configuration: NUM_PCU=2, NUM_UCC=1, NUM_QBCTRL=2, NUM_UC=2, NUM_QB=4, NUM_PQ=32.
REQ-025 Basic scatter:
- Stimulus: entry0 valid pch=1, entry1 valid pch=3; uc=1; qb={K1=2,K0=0}; mask=4'b1011; special=4'b0010; start.
- Required response: ext_valid 6 cycles later; mask_ext bits {12,14,30} set; special_ext bit 14 set; idx_err=0.
REQ-026 Invalid entry: same stimulus as REQ-025 with entry1 valid=0 -> mask_ext bits {12,14} only.
REQ-027 Out of range: entry1 pch=4 -> T=36, 38 not written; idx_err=1; bits 12,14 still set.
REQ-028 Backpressure and start during a pass:
- Hold ext_ready=0 for 10 cycles -> ext_valid and arrays stable throughout.
- start pulsed during SCAN/DONE -> ignored.
- ext_ready=1 -> IDLE next cycle.
REQ-029 Collision: both entries pch=1, mask=4'b0001 -> bit 12 ends 0 (sidx2 overwrites sidx0).
REQ-030 Reset mid-SCAN: rst_n low at sidx=2 -> outputs all 0 asynchronously; new start completes normally.
